pattern_reader: RTL and testbench

PATTERN_READER -- requirements
Module: pattern_reader

---
 rtl/pattern_reader_if.sv | 28 ++
 rtl/pattern_reader.sv | 78 +++++++
 tb/tb_pattern_reader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_reader_if.sv
// Bundle of the command, pattern-memory and pixel-stream signals of the glyph reader.
interface pattern_reader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_char;
  logic [7:0]  cmd_fg;
  logic [7:0]  cmd_bg;
  logic [15:0] pattern_address;
  logic [31:0] pattern_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_eol;
  logic        pix_last;
  logic        busy;

  // Requester / memory / pixel-consumer side.
  modport master (
    output cmd_valid, cmd_char, cmd_fg, cmd_bg, pattern_data, pix_ready,
    input  cmd_ready, pattern_address, pix_valid, pix_data, pix_eol, pix_last, busy
  );

  // Glyph reader side.
  modport slave (
    input  cmd_valid, cmd_char, cmd_fg, cmd_bg, pattern_data, pix_ready,
    output cmd_ready, pattern_address, pix_valid, pix_data, pix_eol, pix_last, busy
  );
endinterface

// File: rtl/pattern_reader.sv
// Glyph reader: fetches the four pattern words of an 8x16 glyph and streams
// 128 colour pixels, one pattern word (4 rows) at a time.
module pattern_reader #(
  parameter logic [15:0] FONT_BASE = 16'h0000
) (
  input  logic           clock,
  input  logic           reset_n,
  pattern_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, EMIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  ch, fg, bg;
  logic [1:0]  word;
  logic [4:0]  pix;
  logic [31:0] pat;
  logic        accept, pix_fire, pat_bit;

  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign pix_fire = (state == EMIT) && bus.pix_ready;
  // Row k of the word sits in byte k, column c is bit 7-c of that byte.
  assign pat_bit  = pat[{pix[4:3], ~pix[2:0]}];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: one fetch/wait bubble per word, leave after pixel 31 of word 3.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = EMIT;
      EMIT:    if (pix_fire && (pix == 5'd31)) state_nxt = (word == 2'd3) ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, word/pixel counters and captured pattern word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ch   <= '0;
      fg   <= '0;
      bg   <= '0;
      word <= '0;
      pix  <= '0;
      pat  <= '0;
    end else begin
      if (accept) begin
        ch   <= bus.cmd_char;
        fg   <= bus.cmd_fg;
        bg   <= bus.cmd_bg;
        word <= '0;
      end
      if (state == WAIT) begin
        pat <= bus.pattern_data;
        pix <= '0;
      end
      if (pix_fire) begin
        pix <= pix + 5'd1;
        if ((pix == 5'd31) && (word != 2'd3)) word <= word + 2'd1;
      end
    end
  end

  // Address comes only from latched glyph index and word counter (16-bit wrap).
  assign bus.pattern_address = FONT_BASE + {4'h0, ch, 4'h0} + {12'h000, word, 2'b00};

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.pix_valid = (state == EMIT);
  assign bus.pix_data  = (state == EMIT) ? (pat_bit ? fg : bg) : 8'h00;
  assign bus.pix_eol   = (state == EMIT) && (&pix[2:0]);
  assign bus.pix_last  = (state == EMIT) && (word == 2'd3) && (&pix);
endmodule

// File: tb/tb_pattern_reader.sv
// Randomised/directed bench for pattern_reader, reference model built from the
// glyph format rules (row/column -> word/byte/bit) over a sparse memory model.
module tb_pattern_reader;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  pattern_reader_if if0 ();
  pattern_reader_if if1 ();

  pattern_reader #(.FONT_BASE(16'h0000)) dut0 (.clock(clock), .reset_n(reset_n), .bus(if0.slave));
  pattern_reader #(.FONT_BASE(16'hFFF0)) dut1 (.clock(clock), .reset_n(reset_n), .bus(if1.slave));

  // Stimulus shared by both instances; cmd_valid steered by sel.
  logic       sel;
  logic       cmd_valid, pix_ready;
  logic [7:0] cmd_char, cmd_fg, cmd_bg;

  assign if0.cmd_valid = cmd_valid & ~sel;
  assign if1.cmd_valid = cmd_valid & sel;
  assign if0.cmd_char = cmd_char;  assign if1.cmd_char = cmd_char;
  assign if0.cmd_fg   = cmd_fg;    assign if1.cmd_fg   = cmd_fg;
  assign if0.cmd_bg   = cmd_bg;    assign if1.cmd_bg   = cmd_bg;
  assign if0.pix_ready = pix_ready;
  assign if1.pix_ready = pix_ready;

  // Sparse pattern memory; unwritten words come from a hash of the address.
  logic [31:0] mem [logic [15:0]];

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = {16'h0, a} * 32'h9E37_79B1;
    return h ^ {a, ~a};
  endfunction

  logic [31:0] pd0, pd1;
  always @(posedge clock) begin
    pd0 <= mem_rd(if0.pattern_address);
    pd1 <= mem_rd(if1.pattern_address);
  end
  assign if0.pattern_data = pd0;
  assign if1.pattern_data = pd1;

  // Observed outputs of the selected instance.
  logic        o_ready, o_valid, o_eol, o_last, o_busy;
  logic [7:0]  o_data;
  logic [15:0] o_addr;
  assign o_ready = sel ? if1.cmd_ready       : if0.cmd_ready;
  assign o_valid = sel ? if1.pix_valid       : if0.pix_valid;
  assign o_eol   = sel ? if1.pix_eol         : if0.pix_eol;
  assign o_last  = sel ? if1.pix_last        : if0.pix_last;
  assign o_busy  = sel ? if1.busy            : if0.busy;
  assign o_data  = sel ? if1.pix_data        : if0.pix_data;
  assign o_addr  = sel ? if1.pattern_address : if0.pattern_address;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Results of the latest render.
  logic [7:0]  got_pix [128];
  logic [15:0] got_addr [$];

  // Issue one glyph command (called at a negedge with the DUT idle) and check
  // every pixel, the fetch addresses, latency and bubbles against the model.
  task automatic render(input bit s, input logic [7:0] g, input logic [7:0] fg,
                        input logic [7:0] bg, input bit rnd, input bit hold, input int abort_at);
    logic [15:0] base, a;
    logic [31:0] w;
    logic [7:0]  byt;
    logic [7:0]  e_pix [128];
    bit          e_eol [128];
    bit          e_last [128];
    logic [15:0] e_addr [4];
    int n, cyc, first, bub;

    base = s ? 16'hFFF0 : 16'h0000;
    for (int wi = 0; wi < 4; wi++) e_addr[wi] = base + 16'(g) * 16'd16 + 16'(wi * 4);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) begin
        a   = base + 16'(g) * 16'd16 + 16'((r / 4) * 4);
        w   = mem_rd(a);
        byt = w[8 * (r % 4) +: 8];
        e_pix[r * 8 + c]  = byt[7 - c] ? fg : bg;
        e_eol[r * 8 + c]  = (c == 7);
        e_last[r * 8 + c] = (r * 8 + c == 127);
      end

    sel = s;
    cmd_valid = 1'b1; cmd_char = g; cmd_fg = fg; cmd_bg = bg;
    check("ready_before_cmd", o_ready, 1);
    check("idle_not_busy", o_busy, 0);
    @(posedge clock);
    n = 0; cyc = 0; first = 0; bub = 0;
    got_addr.delete();
    while (n < 128 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (hold) begin
        cmd_char = 8'($urandom); cmd_fg = 8'($urandom); cmd_bg = 8'($urandom);
      end else cmd_valid = 1'b0;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && n == abort_at && o_valid) begin
        cmd_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort_valid", o_valid, 0);
        check("abort_busy", o_busy, 0);
        check("abort_data", o_data, 0);
        check("abort_eol_last", {o_eol, o_last}, 0);
        check("abort_addr", o_addr, base);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_abort_busy", o_busy, 0);
        check("post_abort_ready", o_ready, 1);
        check("post_abort_valid", o_valid, 0);
        return;
      end
      check("busy_in_glyph", o_busy, 1);
      check("ready_low_in_glyph", o_ready, 0);
      if (o_valid) begin
        if (first == 0) first = cyc;
        check($sformatf("pix%0d_data", n), o_data, e_pix[n]);
        check($sformatf("pix%0d_eol", n), o_eol, e_eol[n]);
        check($sformatf("pix%0d_last", n), o_last, e_last[n]);
        got_pix[n] = o_data;
        if (pix_ready) n++;
      end else begin
        bub++;
        if (got_addr.size() == 0 || got_addr[$] != o_addr) got_addr.push_back(o_addr);
      end
    end
    check("pixel_count", n, 128);
    check("first_valid_cycle", first, 3);
    check("bubble_cycles", bub, 8);
    check("addr_count", got_addr.size(), 4);
    for (int wi = 0; wi < 4 && wi < got_addr.size(); wi++)
      check($sformatf("addr_w%0d", wi), got_addr[wi], e_addr[wi]);
    @(negedge clock);
    check("end_idle_busy", o_busy, 0);
    check("end_idle_ready", o_ready, 1);
    check("end_idle_valid", o_valid, 0);
  endtask

  initial begin
    sel = 1'b0; cmd_valid = 1'b0; pix_ready = 1'b1;
    cmd_char = 8'h00; cmd_fg = 8'h00; cmd_bg = 8'h00;
    for (int i = 0; i < 4; i++) mem[16'h0410 + 16'(i * 4)] = 32'h8100_FF01;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid0", if0.pix_valid, 0);
    check("rst_busy0", if0.busy, 0);
    check("rst_data0", if0.pix_data, 0);
    check("rst_eol_last0", {if0.pix_eol, if0.pix_last}, 0);
    check("rst_addr0", if0.pattern_address, 16'h0000);
    check("rst_addr1", if1.pattern_address, 16'hFFF0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rel_ready0", if0.cmd_ready, 1);
    check("rel_ready1", if1.cmd_ready, 1);

    // Directed glyph 0x41 with full-rate consumer, then with random stalls.
    render(1'b0, 8'h41, 8'h0F, 8'h00, 1'b0, 1'b0, -1);
    check("dir_addr0", got_addr[0], 16'h0410);
    check("dir_addr3", got_addr[3], 16'h041C);
    check("dir_row0_c0", got_pix[0], 8'h00);
    check("dir_row0_c7", got_pix[7], 8'h0F);
    check("dir_row1_c3", got_pix[11], 8'h0F);
    check("dir_row2_c5", got_pix[21], 8'h00);
    check("dir_row3_c0", got_pix[24], 8'h0F);
    check("dir_row3_c1", got_pix[25], 8'h00);
    check("dir_row3_c7", got_pix[31], 8'h0F);
    render(1'b0, 8'h41, 8'h0F, 8'h00, 1'b1, 1'b0, -1);
    check("stall_row0_c7", got_pix[7], 8'h0F);

    // Random glyphs/colours over hashed memory contents.
    for (int k = 0; k < 3; k++)
      render(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, -1);

    // Address wrap with a high font base.
    render(1'b1, 8'h01, 8'hAA, 8'h55, 1'b1, 1'b0, -1);
    check("wrap_addr0", got_addr[0], 16'h0000);
    check("wrap_addr3", got_addr[3], 16'h000C);

    // Reset in the middle of pixel 40, then a clean glyph.
    render(1'b0, 8'h41, 8'h0F, 8'h00, 1'b0, 1'b0, 40);
    repeat (2) begin
      @(negedge clock);
      check("no_pix_after_abort", o_valid, 0);
    end
    render(1'b0, 8'h41, 8'h0F, 8'h00, 1'b1, 1'b0, -1);
    check("after_abort_row1", got_pix[8], 8'h0F);

    // cmd_valid held high: one acceptance per glyph, busy-time commands ignored.
    render(1'b0, 8'h41, 8'h3C, 8'hC3, 1'b1, 1'b1, -1);
    render(1'b0, 8'h7E, 8'h11, 8'h22, 1'b0, 1'b1, -1);
    cmd_valid = 1'b0;
    @(negedge clock);
    check("hold_stop_idle", o_busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
